// File: rtl/aion_burn_state_filter_v2_pkg.sv
// rtl/aion_burn_state_filter_v2_pkg.sv - shared types and defaults for the burn state filter
package aion_burn_types_v2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } filt_state_e;

  localparam int ALPHA_SHIFT_DEF = 3;
  localparam int TRIP_COUNT_DEF  = 4;
  // Trip counters never need to exceed 15.
  localparam int CNT_W           = 4;

  typedef logic signed [31:0] q16_16_t;

  typedef struct packed {
    q16_16_t temp;
    q16_16_t palpha;
    q16_16_t beta;
  } thermal_sample_t;

endpackage

// File: rtl/aion_burn_state_filter_v2_ema_step.sv
// rtl/aion_burn_state_filter_v2_ema_step.sv - single-field EMA step with unprimed bypass
module aion_ema_step #(
  parameter int DATA_W      = 32,
  parameter int ALPHA_SHIFT = 3
) (
  input  logic              primed_i,
  input  logic [DATA_W-1:0] x_i,
  input  logic [DATA_W-1:0] y_i,
  output logic [DATA_W-1:0] y_o
);

  logic [DATA_W:0] diff_w;
  logic [DATA_W:0] step_w;

  // One extra bit keeps x-y exact; the shifted step always fits back into DATA_W.
  always_comb begin
    diff_w = {x_i[DATA_W-1], x_i} - {y_i[DATA_W-1], y_i};
    step_w = $unsigned($signed(diff_w) >>> ALPHA_SHIFT);
    y_o    = primed_i ? (y_i + step_w[DATA_W-1:0]) : x_i;
  end

endmodule

// File: rtl/aion_burn_state_filter_v2.sv
// rtl/aion_burn_state_filter_v2.sv - per-channel EMA filter with debounced sticky trips (option: AION_BURN_FILT_DERIV_EN)
module aion_burn_state_filter_v2
  import aion_burn_types_v2::*;
#(
  parameter int  N_CH        = 4,
  parameter int  DATA_W      = 32,
  parameter int  ALPHA_SHIFT = ALPHA_SHIFT_DEF,
  parameter int  TRIP_COUNT  = TRIP_COUNT_DEF,
  localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_temp,
  input  logic [DATA_W-1:0] in_palpha,
  input  logic [DATA_W-1:0] in_beta,
  input  logic [DATA_W-1:0] cfg_temp_limit,
  input  logic [DATA_W-1:0] cfg_beta_limit,
  input  logic              clear_trip,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_ch,
  output logic [DATA_W-1:0] out_temp,
  output logic [DATA_W-1:0] out_palpha,
  output logic [DATA_W-1:0] out_beta,
  output logic [N_CH-1:0]   trip,
  output logic              trip_any
`ifdef AION_BURN_FILT_DERIV_EN
  ,
  output logic [DATA_W-1:0] out_dtemp
`endif
);

  filt_state_e       state_q;
  logic              in_ready_q, out_valid_q;
  logic [CH_W-1:0]   ch_q, out_ch_q;
  logic [DATA_W-1:0] x_temp_q, x_palpha_q, x_beta_q;
  logic [DATA_W-1:0] out_temp_q, out_palpha_q, out_beta_q;
  logic [N_CH-1:0]   primed_q, trip_q, trip_d;
  logic              trip_any_q;
  logic [DATA_W-1:0] y_temp_q   [N_CH];
  logic [DATA_W-1:0] y_palpha_q [N_CH];
  logic [DATA_W-1:0] y_beta_q   [N_CH];
  logic [CNT_W-1:0]  cnt_q      [N_CH];
  logic [CNT_W-1:0]  cnt_d      [N_CH];

  logic              ch_ok;
  logic [CH_W-1:0]   ch_idx;
  logic [DATA_W-1:0] new_temp, new_palpha, new_beta;
  logic              over, set_trip;
  logic [CNT_W-1:0]  cnt_new;

  // Out-of-range channels are steered to index 0 but never written.
  assign ch_ok  = int'(ch_q) < N_CH;
  assign ch_idx = ch_ok ? ch_q : '0;

  aion_ema_step #(.DATA_W(DATA_W), .ALPHA_SHIFT(ALPHA_SHIFT)) u_ema_temp (
    .primed_i(primed_q[ch_idx]), .x_i(x_temp_q),   .y_i(y_temp_q[ch_idx]),   .y_o(new_temp));
  aion_ema_step #(.DATA_W(DATA_W), .ALPHA_SHIFT(ALPHA_SHIFT)) u_ema_palpha (
    .primed_i(primed_q[ch_idx]), .x_i(x_palpha_q), .y_i(y_palpha_q[ch_idx]), .y_o(new_palpha));
  aion_ema_step #(.DATA_W(DATA_W), .ALPHA_SHIFT(ALPHA_SHIFT)) u_ema_beta (
    .primed_i(primed_q[ch_idx]), .x_i(x_beta_q),   .y_i(y_beta_q[ch_idx]),   .y_o(new_beta));

  assign over = ($signed(new_temp) > $signed(cfg_temp_limit)) ||
                ($signed(new_beta) > $signed(cfg_beta_limit));

  assign cnt_new  = !over ? '0 :
                    (cnt_q[ch_idx] == CNT_W'(TRIP_COUNT)) ? cnt_q[ch_idx] : cnt_q[ch_idx] + 1'b1;
  assign set_trip = over && (cnt_new == CNT_W'(TRIP_COUNT));

  // Trip bookkeeping: a global clear first, then the channel under calculation overrides it.
  always_comb begin
    trip_d = trip_q;
    for (int i = 0; i < N_CH; i++) cnt_d[i] = cnt_q[i];
    if (clear_trip) begin
      trip_d = '0;
      for (int i = 0; i < N_CH; i++) cnt_d[i] = '0;
    end
    if (state_q == CALC && ch_ok) begin
      cnt_d[ch_idx] = cnt_new;
      if (set_trip) trip_d[ch_idx] = 1'b1;
    end
  end

`ifdef AION_BURN_FILT_DERIV_EN
  logic [DATA_W:0]   dtemp_w;
  logic [DATA_W-1:0] dtemp_sat, out_dtemp_q;

  // Temperature slope between consecutive filtered values, clamped to the signed range.
  always_comb begin
    dtemp_w = {new_temp[DATA_W-1], new_temp} -
              {y_temp_q[ch_idx][DATA_W-1], y_temp_q[ch_idx]};
    if (dtemp_w[DATA_W] != dtemp_w[DATA_W-1])
      dtemp_sat = dtemp_w[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    else
      dtemp_sat = dtemp_w[DATA_W-1:0];
  end

  assign out_dtemp = out_dtemp_q;
`endif

  // Sample FSM: accept, filter and trip-check in one CALC cycle, then hold the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      ch_q         <= '0;
      out_ch_q     <= '0;
      x_temp_q     <= '0;
      x_palpha_q   <= '0;
      x_beta_q     <= '0;
      out_temp_q   <= '0;
      out_palpha_q <= '0;
      out_beta_q   <= '0;
      primed_q     <= '0;
      trip_q       <= '0;
      trip_any_q   <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        y_temp_q[i]   <= '0;
        y_palpha_q[i] <= '0;
        y_beta_q[i]   <= '0;
        cnt_q[i]      <= '0;
      end
`ifdef AION_BURN_FILT_DERIV_EN
      out_dtemp_q  <= '0;
`endif
    end else begin
      trip_q     <= trip_d;
      trip_any_q <= |trip_d;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
      case (state_q)
        IDLE: begin
          if (in_ready_q && in_valid) begin
            ch_q       <= in_ch;
            x_temp_q   <= in_temp;
            x_palpha_q <= in_palpha;
            x_beta_q   <= in_beta;
            in_ready_q <= 1'b0;
            state_q    <= CALC;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        CALC: begin
          if (ch_ok) begin
            primed_q[ch_idx]   <= 1'b1;
            y_temp_q[ch_idx]   <= new_temp;
            y_palpha_q[ch_idx] <= new_palpha;
            y_beta_q[ch_idx]   <= new_beta;
            out_ch_q           <= ch_q;
            out_temp_q         <= new_temp;
            out_palpha_q       <= new_palpha;
            out_beta_q         <= new_beta;
`ifdef AION_BURN_FILT_DERIV_EN
            out_dtemp_q        <= primed_q[ch_idx] ? dtemp_sat : '0;
`endif
            out_valid_q        <= 1'b1;
            state_q            <= OUT;
          end else begin
            in_ready_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_ch     = out_ch_q;
  assign out_temp   = out_temp_q;
  assign out_palpha = out_palpha_q;
  assign out_beta   = out_beta_q;
  assign trip       = trip_q;
  assign trip_any   = trip_any_q;

endmodule

// File: tb/tb_aion_burn_state_filter_v2.sv
// tb/tb_aion_burn_state_filter_v2.sv - self-checking bench for aion_burn_state_filter_v2
module tb_aion_burn_state_filter_v2;

  localparam int N_CH   = 5;
  localparam int DATA_W = 32;
  localparam int ALPHA  = 3;
  localparam int TRIPN  = 4;
  localparam int CH_W   = 3;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, clear_trip, out_valid, out_ready, trip_any;
  logic [CH_W-1:0]   in_ch, out_ch;
  logic [DATA_W-1:0] in_temp, in_palpha, in_beta, cfg_temp_limit, cfg_beta_limit;
  logic [DATA_W-1:0] out_temp, out_palpha, out_beta;
  logic [N_CH-1:0]   trip;
`ifdef AION_BURN_FILT_DERIV_EN
  logic [DATA_W-1:0] out_dtemp;
`endif

  aion_burn_state_filter_v2 #(.N_CH(N_CH), .DATA_W(DATA_W), .ALPHA_SHIFT(ALPHA), .TRIP_COUNT(TRIPN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
    .in_temp(in_temp), .in_palpha(in_palpha), .in_beta(in_beta),
    .cfg_temp_limit(cfg_temp_limit), .cfg_beta_limit(cfg_beta_limit), .clear_trip(clear_trip),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_temp(out_temp),
    .out_palpha(out_palpha), .out_beta(out_beta), .trip(trip), .trip_any(trip_any)
`ifdef AION_BURN_FILT_DERIV_EN
    , .out_dtemp(out_dtemp)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: filter values as plain integers, debounce as counts.
  bit     m_primed [N_CH];
  longint m_t [N_CH], m_p [N_CH], m_b [N_CH];
  int     m_cnt [N_CH];
  bit     m_trip [N_CH];
  logic [DATA_W-1:0] exp_t, exp_p, exp_b;
  logic [CH_W-1:0]   exp_ch;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // y + floor((x - y) / 2^ALPHA), or x when not yet primed.
  function automatic longint ema(input bit pr, input longint y, input longint x);
    longint d, q, den;
    if (!pr) return x;
    den = 1;
    repeat (ALPHA) den = den * 2;
    d = x - y;
    q = d / den;
    if (d < 0 && q * den != d) q = q - 1;
    return y + q;
  endfunction

  function automatic logic [N_CH-1:0] m_trip_vec();
    logic [N_CH-1:0] v;
    for (int i = 0; i < N_CH; i++) v[i] = m_trip[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_primed[i] = 0; m_t[i] = 0; m_p[i] = 0; m_b[i] = 0; m_cnt[i] = 0; m_trip[i] = 0;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N_CH; i++) begin
      m_cnt[i] = 0; m_trip[i] = 0;
    end
  endtask

  // Present one sample, check the CALC cycle, then check the result cycle.
  task automatic send(input int ch, input logic [31:0] t, input logic [31:0] p,
                      input logic [31:0] b, input bit clr_in_calc);
    int n;
    bit over, hit;
    int c;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", in_ready, 1'b1);
    in_valid = 1'b1; in_ch = CH_W'(ch); in_temp = t; in_palpha = p; in_beta = b;
    @(negedge clk);
    in_valid = 1'b0;
    chk("in_ready_calc", in_ready, 1'b0);
    chk("out_valid_calc", out_valid, 1'b0);
    clear_trip = clr_in_calc;
    hit = 0;
    c = 0;
    if (ch < N_CH) begin
      m_t[ch] = ema(m_primed[ch], m_t[ch], longint'($signed(t)));
      m_p[ch] = ema(m_primed[ch], m_p[ch], longint'($signed(p)));
      m_b[ch] = ema(m_primed[ch], m_b[ch], longint'($signed(b)));
      m_primed[ch] = 1;
      over = (m_t[ch] > longint'($signed(cfg_temp_limit))) ||
             (m_b[ch] > longint'($signed(cfg_beta_limit)));
      c = over ? ((m_cnt[ch] >= TRIPN) ? TRIPN : m_cnt[ch] + 1) : 0;
      hit = over && (c == TRIPN);
    end
    if (clr_in_calc) model_clear();
    if (ch < N_CH) begin
      m_cnt[ch] = c;
      if (hit) m_trip[ch] = 1;
    end
    @(negedge clk);
    clear_trip = 1'b0;
    if (ch < N_CH) begin
      exp_t = 32'(m_t[ch]); exp_p = 32'(m_p[ch]); exp_b = 32'(m_b[ch]); exp_ch = CH_W'(ch);
      chk("out_valid", out_valid, 1'b1);
      chk("out_ch", out_ch, exp_ch);
      chk("out_temp", out_temp, exp_t);
      chk("out_palpha", out_palpha, exp_p);
      chk("out_beta", out_beta, exp_b);
    end else begin
      chk("oor_no_out", out_valid, 1'b0);
      chk("oor_ready", in_ready, 1'b1);
    end
    chk("trip", trip, m_trip_vec());
    chk("trip_any", trip_any, |m_trip_vec());
  endtask

  // Hold out_ready low for 'hold' cycles, checking the held result, then take it.
  task automatic consume(input int hold, input bit stray);
    if (stray) begin
      in_valid = 1'b1; in_ch = 3'd1; in_temp = 32'h1234_0000; in_palpha = 32'h0; in_beta = 32'h0;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_ready", in_ready, 1'b0);
      chk("hold_temp", out_temp, exp_t);
      chk("hold_beta", out_beta, exp_b);
      chk("hold_ch", out_ch, exp_ch);
      chk("hold_trip", trip, m_trip_vec());
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("released", out_valid, 1'b0);
  endtask

  initial begin
    logic [31:0] rt, rp, rb;
    int rch;
    rst_n = 1'b0; in_valid = 1'b0; in_ch = '0; in_temp = '0; in_palpha = '0; in_beta = '0;
    cfg_temp_limit = 32'h7FFF_FFFF; cfg_beta_limit = 32'h7FFF_FFFF;
    clear_trip = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_temp", out_temp, 32'h0);
    chk("rst_trip", trip, 5'h0);
    chk("rst_trip_any", trip_any, 1'b0);
    rst_n = 1'b1;

    // Priming then one EMA step on ch0.
    send(0, 32'h000A_0000, 32'h0001_0000, 32'h0000_1000, 0);
    chk("t1_prime", out_temp, 32'h000A_0000);
    consume(0, 0);
    send(0, 32'h0012_0000, 32'h0001_0000, 32'h0000_1000, 0);
    chk("t1_step", out_temp, 32'h000B_0000);
    consume(0, 0);

    // Extreme swing on ch1.
    send(1, 32'h8001_0000, 32'h8001_0000, 32'h8001_0000, 0);
    consume(1, 0);
    send(1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8001_0000, 0);
    chk("t2_extreme", out_temp, 32'hA000_DFFF);
    consume(0, 0);

    // Debounce: four over-limit samples trip ch2; a short burst on ch3 does not.
    cfg_beta_limit = 32'h0000_4000;
    for (int i = 0; i < 4; i++) begin
      send(2, 32'h0, 32'h0, 32'h0000_8000, 0);
      chk("t3_trip2", trip[2], (i == 3) ? 1'b1 : 1'b0);
      consume(0, 0);
    end
    for (int i = 0; i < 3; i++) begin
      send(3, 32'h0, 32'h0, 32'h0000_8000, 0);
      consume(0, 0);
    end
    send(3, 32'h0, 32'h0, 32'hFFF0_0000, 0);
    chk("t3_no_trip3", trip[3], 1'b0);
    consume(0, 0);

    // Backpressure with a stray request and a limit change while holding.
    send(0, 32'h0020_0000, 32'h0, 32'h0, 0);
    cfg_beta_limit = 32'h8000_0000;
    consume(5, 1);
    cfg_beta_limit = 32'h0000_4000;
    send(1, 32'h1234_0000, 32'h0, 32'h0, 0);
    consume(0, 0);

    // Out-of-range channels, then clear racing a trip on ch2.
    send(7, 32'h7000_0000, 32'h7000_0000, 32'h7000_0000, 0);
    send(5, 32'h7000_0000, 32'h7000_0000, 32'h7000_0000, 0);
    send(0, 32'h0020_0000, 32'h0, 32'h0, 0);
    consume(0, 0);
    clear_trip = 1'b1;
    model_clear();
    @(negedge clk);
    clear_trip = 1'b0;
    chk("t5_cleared", trip, 5'h0);
    for (int i = 0; i < 4; i++) begin
      send(2, 32'h0, 32'h0, 32'h0000_8000, (i == 3));
      consume(0, 0);
    end
    chk("t5_set_wins", trip[2], 1'b1);

    // Reset while a result is held; the next sample re-primes.
    send(1, 32'h0003_0000, 32'h0, 32'h0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    model_reset();
    chk("t6_valid", out_valid, 1'b0);
    chk("t6_trip", trip, 5'h0);
    chk("t6_trip_any", trip_any, 1'b0);
    rst_n = 1'b1;
    send(1, 32'h0005_0000, 32'h0006_0000, 32'h0007_0000, 0);
    chk("t6_reprime", out_temp, 32'h0005_0000);
    consume(0, 0);

    // Randomised traffic against the reference model.
    for (int k = 0; k < 40; k++) begin
      rch = $urandom_range(0, 6);
      rt = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 32'h0006_0000);
      rp = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 32'h0006_0000);
      cfg_temp_limit = $urandom_range(0, 32'h0006_0000);
      cfg_beta_limit = $urandom_range(0, 32'h0006_0000);
      if ($urandom_range(0, 7) == 0) begin
        clear_trip = 1'b1;
        model_clear();
        @(negedge clk);
        clear_trip = 1'b0;
      end
      send(rch, rt, rp, rb, 0);
      if (rch < N_CH) consume($urandom_range(0, 3), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
